// File: rtl/newhope_pkg.sv
// Shared NewHope constants and the polynomial sequencer state type.
package newhope_pkg;

    localparam int NEWHOPE_Q      = 12289;
    localparam int N_512          = 512;
    localparam int N_1024         = 1024;
    localparam int N_DEFAULT      = N_1024;
    localparam int ADDR_W_DEFAULT = 10;
    localparam int COEFF_DATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } poly_ctrl_state_t;

endpackage

// File: rtl/poly_sub_coeff.sv
// One-coefficient subtract/reduce unit: dout = |a - b| mod q, fixed 3-cycle latency,
// accepts one pair per cycle and never stalls.
module poly_sub_coeff
    import newhope_pkg::*;
#(
    parameter int DATA_W = COEFF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam logic [DATA_W-1:0] Q1 = DATA_W'(NEWHOPE_Q);
    localparam logic [DATA_W-1:0] Q2 = DATA_W'(2 * NEWHOPE_Q);
    localparam logic [DATA_W-1:0] Q4 = DATA_W'(4 * NEWHOPE_Q);

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        return d[DATA_W] ? DATA_W'(-d) : DATA_W'(d);
    endfunction

    function automatic logic [DATA_W-1:0] cond_sub(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] k);
        return (x >= k) ? x - k : x;
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    logic [DATA_W-1:0] mag_p0, mag_p1, res_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= start;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // p0: magnitude of the difference; p1: fold below 2q; p2: fold below q.
    // A 16-bit magnitude is under 5.34q, so 4q, 2q, q steps always land in [0, q).
    always_ff @(posedge clk) begin
        mag_p0 <= abs_diff(a, b);
        mag_p1 <= cond_sub(cond_sub(mag_p0, Q4), Q2);
        res_p2 <= cond_sub(mag_p1, Q1);
    end

    assign done = vld_p2;
    assign dout = res_p2;

endmodule

// File: rtl/poly_sub_ctrl.sv
// Polynomial subtraction sequencer: streams N coefficient pairs through poly_sub_coeff
// and writes the reduced results back, finishing with a one-cycle done pulse.
module poly_sub_ctrl
    import newhope_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       dia,
    input  logic [15:0]       dib,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done
);

    // One spare counter bit keeps N == 2**ADDR_W from wrapping back onto 0.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    poly_ctrl_state_t state, state_next;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic             rd_vld_p0;
    logic             coeff_done;
    logic [15:0]      coeff_dout;
    logic             last_rd, last_wr;

    assign last_rd = (rd_cnt == LAST);
    assign last_wr = coeff_done && (wr_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (last_rd) state_next = last_wr ? FINISH : DRAIN;
            DRAIN:   if (last_wr) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state == READ);
        rd_addr = rd_en ? rd_cnt[ADDR_W-1:0] : '0;
        busy    = (state == READ) || (state == DRAIN);
        done    = (state == FINISH);
        wr_en   = coeff_done;
        wr_addr = coeff_done ? wr_cnt[ADDR_W-1:0] : '0;
        wr_data = coeff_done ? (coeff_dout & 16'h3FFF) : '0;
    end

    // Write counter follows the unit's done, so it is independent of the unit latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_vld_p0 <= 1'b0;
        end else begin
            rd_vld_p0 <= rd_en;
            if (state == IDLE && start) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (state == READ) rd_cnt <= rd_cnt + CNT_W'(1);
                if (coeff_done)    wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    poly_sub_coeff #(
        .DATA_W(16)
    ) u_coeff (
        .clk  (clk),
        .rst  (rst),
        .start(rd_vld_p0),
        .a    (dia),
        .b    (dib),
        .done (coeff_done),
        .dout (coeff_dout)
    );

    // More than N results in one operation means the unit produced a stray done.
    a_no_extra_write: assert property (@(posedge clk) disable iff (rst)
        coeff_done |-> (wr_cnt < CNT_W'(N)));

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Bench for poly_sub_ctrl: an 8-entry and a 1024-entry instance share a RAM model,
// and every operation is checked against |A-B| mod q computed from the source arrays.
module tb_poly_sub_ctrl;

    localparam int Q   = 12289;
    localparam int L   = 3;
    localparam int NA  = 8;
    localparam int AWA = 3;
    localparam int NB  = 1024;
    localparam int AWB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st  = 1'b0;
    logic sel = 1'b0;
    logic [15:0] dia = '0;
    logic [15:0] dib = '0;

    logic start_a, start_b;
    logic rd_en_a, wr_en_a, busy_a, done_a;
    logic [AWA-1:0] rd_addr_a, wr_addr_a;
    logic [15:0] wr_data_a;
    logic rd_en_b, wr_en_b, busy_b, done_b;
    logic [AWB-1:0] rd_addr_b, wr_addr_b;
    logic [15:0] wr_data_b;

    assign start_a = st & ~sel;
    assign start_b = st & sel;

    poly_sub_ctrl #(.N(NA), .ADDR_W(AWA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .dia(dia), .dib(dib),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a)
    );

    poly_sub_ctrl #(.N(NB), .ADDR_W(AWB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .dia(dia), .dib(dib),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b)
    );

    logic m_rd_en, m_wr_en, m_busy, m_done;
    logic [9:0] m_rd_addr, m_wr_addr;
    logic [15:0] m_wr_data;

    assign m_rd_en   = sel ? rd_en_b   : rd_en_a;
    assign m_rd_addr = sel ? rd_addr_b : 10'(rd_addr_a);
    assign m_wr_en   = sel ? wr_en_b   : wr_en_a;
    assign m_wr_addr = sel ? wr_addr_b : 10'(wr_addr_a);
    assign m_wr_data = sel ? wr_data_b : wr_data_a;
    assign m_busy    = sel ? busy_b    : busy_a;
    assign m_done    = sel ? done_b    : done_a;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    // Synchronous-read source RAMs: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (m_rd_en) begin
            dia <= mem_a[m_rd_addr];
            dib <= mem_b[m_rd_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;
    int op_c0 = 0;
    int cur_n = 0;
    int rel;
    int rd_total, rd_err, wr_total, wr_err, busy_err, done_cnt, done_rel;
    int hits [1024];
    logic [15:0] got [1024];

    // Transaction log; rel is the cycle index counted from the cycle start was sampled.
    always @(negedge clk) begin
        if (mon_on) begin
            rel = cyc - op_c0;
            if (m_rd_en) begin
                if (int'(m_rd_addr) != rd_total || rel != rd_total + 1) rd_err++;
                rd_total++;
            end
            if (m_wr_en) begin
                hits[m_wr_addr]++;
                got[m_wr_addr] = m_wr_data;
                if (int'(m_wr_addr) != wr_total || rel != wr_total + L + 2) wr_err++;
                wr_total++;
            end
            if (m_done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (m_busy !== (rel >= 1 && rel <= cur_n + L + 1)) busy_err++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_coef(input int i);
        int d;
        d = int'(mem_a[i]) - int'(mem_b[i]);
        if (d < 0) d = -d;
        return d % Q;
    endfunction

    task automatic clear_log();
        rd_total = 0; rd_err = 0; wr_total = 0; wr_err = 0;
        busy_err = 0; done_cnt = 0; done_rel = -1;
        for (int i = 0; i < 1024; i++) begin
            hits[i] = 0;
            got[i]  = '0;
        end
    endtask

    task automatic begin_op(input bit which, input int n);
        @(negedge clk);
        sel = which;
        clear_log();
        cur_n = n;
        op_c0 = cyc;
        st = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit hold);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            if (!hold) st = 1'b0;
            k++;
        end while (!m_done && k < budget);
        st = 1'b0;
        #1;
        chk({tag, "/done_seen"}, int'(m_done), 1);
    endtask

    task automatic tail(input int k);
        repeat (k) @(negedge clk);
        #1;
        mon_on = 1'b0;
    endtask

    task automatic check_op(input string tag, input int n);
        chk({tag, "/done_cnt"}, done_cnt, 1);
        chk({tag, "/done_cycle"}, done_rel, n + L + 2);
        chk({tag, "/rd_total"}, rd_total, n);
        chk({tag, "/rd_order"}, rd_err, 0);
        chk({tag, "/wr_total"}, wr_total, n);
        chk({tag, "/wr_order"}, wr_err, 0);
        chk({tag, "/busy"}, busy_err, 0);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/hits[%0d]", tag, i), hits[i], 1);
            chk($sformatf("%s/data[%0d]", tag, i), int'(got[i]), ref_coef(i));
        end
    endtask

    task automatic load_rand();
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
    endtask

    initial begin
        // Reset state of both instances
        #1;
        chk("rst/a_rd_en", int'(rd_en_a), 0);
        chk("rst/a_wr_en", int'(wr_en_a), 0);
        chk("rst/a_busy", int'(busy_a), 0);
        chk("rst/a_done", int'(done_a), 0);
        chk("rst/a_wr_data", int'(wr_data_a), 0);
        chk("rst/b_rd_en", int'(rd_en_b), 0);
        chk("rst/b_busy", int'(busy_b), 0);
        chk("rst/b_done", int'(done_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic: every difference is 150
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'(200 + i);
            mem_b[i] = 16'(50 + i);
        end
        begin_op(1'b0, NA);
        wait_done("basic", 100, 1'b0);
        tail(6);
        check_op("basic", NA);
        chk("basic/const150", int'(got[5]), 150);

        // Reduction of an input above q
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'd12300;
            mem_b[i] = 16'd0;
        end
        begin_op(1'b0, NA);
        wait_done("red_hi", 100, 1'b0);
        tail(6);
        check_op("red_hi", NA);
        chk("red_hi/const11", int'(got[0]), 11);

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'd0;
            mem_b[i] = 16'd1;
        end
        begin_op(1'b0, NA);
        wait_done("red_lo", 100, 1'b0);
        tail(6);
        check_op("red_lo", NA);
        chk("red_lo/const1", int'(got[7]), 1);

        // Random full-range operands
        load_rand();
        begin_op(1'b0, NA);
        wait_done("rand8", 100, 1'b0);
        tail(6);
        check_op("rand8", NA);

        // Reset in the middle of an operation
        load_rand();
        begin_op(1'b0, NA);
        @(negedge clk);
        st = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst/pre_wr_en", int'(wr_en_a), 1);
        chk("midrst/pre_rd_en", int'(rd_en_a), 1);
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst/rd_en", int'(rd_en_a), 0);
        chk("midrst/wr_en", int'(wr_en_a), 0);
        chk("midrst/busy", int'(busy_a), 0);
        chk("midrst/done", int'(done_a), 0);
        @(negedge clk);
        chk("midrst/busy_hold", int'(busy_a), 0);
        rst = 1'b0;
        load_rand();
        begin_op(1'b0, NA);
        wait_done("after_rst", 100, 1'b0);
        tail(6);
        check_op("after_rst", NA);

        // start held high for a whole 1024-point operation
        load_rand();
        begin_op(1'b1, NB);
        wait_done("held", 2000, 1'b1);
        check_op("held", NB);

        // Address coverage, started the cycle after done
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'(i);
            mem_b[i] = 16'd0;
        end
        begin_op(1'b1, NB);
        wait_done("addr_cov", 2000, 1'b0);
        tail(6);
        check_op("addr_cov", NB);
        chk("addr_cov/last", int'(got[1023]), 1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_sub_ctrl.md
# poly_sub_ctrl

Sequencer that runs a full NewHope polynomial subtraction by streaming coefficient pairs from two read ports through one `poly_sub_coeff` unit and writing the reduced results back. It sits between the polynomial RAMs and the top-level protocol FSM. It issues one read per cycle, tracks in-flight results with a done-driven write counter, and signals completion with a one-cycle `done` pulse.

## Interface
- `N`, 1024: coefficients per polynomial; 512 and 1024 must be supported, small powers of two are used for simulation.
- `ADDR_W`, 10: address width; must satisfy 2^ADDR_W >= N.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin an operation; sampled only in IDLE.
- `rd_en` out 1: read strobe to both source RAMs.
- `rd_addr` out ADDR_W: shared read address for RAM A and RAM B.
- `dia` in 16: RAM A read data, valid one cycle after `rd_en`.
- `dib` in 16: RAM B read data, valid one cycle after `rd_en`.
- `wr_en` out 1: destination RAM write strobe.
- `wr_addr` out ADDR_W: destination address.
- `wr_data` out 16: reduced coefficient, upper 2 bits always 0.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `start`=1 moves to READ and clears `rd_cnt` and `wr_cnt`.
  - READ: asserts `rd_en` with `rd_addr`=`rd_cnt` and increments `rd_cnt` every cycle. After issuing address N-1, moves to DRAIN.
  - DRAIN: `rd_en`=0; waits for the remaining results.
  - FINISH: `done`=1 for exactly one cycle, then returns to IDLE.
- Data path:
  - `rd_en` is delayed one cycle to form the coefficient unit's `start`.
  - `dia` and `dib` feed the unit directly.
- Write side:
  - Each cycle the unit's `done` is high: `wr_en`=1, `wr_addr`=`wr_cnt`, `wr_data`=unit `dout`. Then `wr_cnt` increments.
  - The write side is independent of the unit's internal latency. The pipeline never stalls.
- Leaving DRAIN: when the write to address N-1 is issued, the next state is FINISH, independent of READ/DRAIN timing.
- `start` while busy (READ, DRAIN or FINISH) is ignored. No queueing.
- Counters are ADDR_W+1 bits wide, so N=2^ADDR_W terminates without wrap ambiguity.
- Reset values: all outputs 0, state IDLE, counters 0. The coefficient unit is reset by the same `rst`.
- Reset mid-operation: immediately returns to IDLE and drops `rd_en`/`wr_en`. Partial results in the destination RAM are undefined. No `done` is issued.
- `wr_en` must not be asserted more than N times per operation; any extra unit `done` is a design error, flagged by an assertion.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: `busy`=1, `rd_en`=1, `rd_addr`=0.
- Cycle k+1: `rd_addr`=k for k=0..N-1, contiguous with no bubbles.
- Cycle k+2: RAM data for address k arrives and the unit `start` is high.
- Let L = the unit's start-to-done latency. The write of address k occurs at cycle k+2+L.
- `done` is high at cycle N+2+L. `busy` falls in the same cycle `done` rises.
- Total operation length: N+2+L cycles. The next `start` is accepted in the cycle after `done`.

## Structure
- Shared package `newhope_pkg` holds:
  - `NEWHOPE_Q` = 12289.
  - `N` defaults (512/1024) and `ADDR_W`.
  - The state enum typedef `poly_ctrl_state_t` (IDLE, READ, DRAIN, FINISH).
- One sub-module: `poly_sub_coeff`, instantiated once.
- Two counters and a 1-bit read-valid delay register live in this block. No FIFO is needed.

## Test plan
- **Basic, N=8:** A[i]=200+i, B[i]=50+i, `start` pulse → 8 writes to addresses 0..7 with `wr_data`=150. `done` at cycle 10+L, exactly one pulse.
- **Reduction, N=8:** A[i]=12300, B[i]=0 → every `wr_data`=11. A[i]=0, B[i]=1 → every `wr_data`=1.
- **Ignored start, N=1024:** `start` held high for the whole operation → exactly 1024 writes and one `done`. A second `start` at `done`+1 cycle is accepted.
- **Reset mid-operation, N=8:** assert `rst` at cycle 5 → `rd_en`, `wr_en`, `busy` and `done` are 0 within the reset. A fresh `start` then completes normally with correct data.
- **Address coverage, N=1024:** A[i]=i, B[i]=0 → `wr_data`=i at `wr_addr`=i for all i. No gaps, no duplicates, contiguous `rd_addr` 0..1023.
